// File: rtl/alu_pkg.sv
// Shared opcode encoding, error codes and stage state encoding for the ALU operand stage.
package alu_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd2;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'd4;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'd5;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'd6;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'd7;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'd8;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd9;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd10;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'd11;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'd12;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;
    localparam logic [1:0] ERR_WDOG    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    function automatic logic is_multi(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_shift(input logic [OPC_W-1:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SHRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classification used when operands are latched.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic             legal_o,
    output logic             multi_o,
    output logic             shift_o,
    output logic             unary_o
);

    // Opcodes are packed densely from ADD up to NOT; anything above is unused.
    assign legal_o = (opcode_i <= OP_NOT);
    assign multi_o = is_multi(opcode_i);
    assign shift_o = is_shift(opcode_i);
    assign unary_o = (opcode_i == OP_NEG) || (opcode_i == OP_NOT);

endmodule

// File: rtl/alu_op_stage.sv
// Operand/result staging around the ALU: latches one op, sequences single- and
// multi-cycle execution, guards multi-cycle ops with a watchdog, holds the result.
//
//  state | meaning
//  IDLE  | ready for a new op (in_ready_o high)
//  EXEC  | operands presented; single-cycle result captured, or MUL/DIV started
//  WAIT  | waiting for alu_done_i, watchdog counting down
//  OUT   | result valid, held until out_ready_i
module alu_op_stage
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int WDOG    = 40
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OPC_W-1:0]  alu_op_o,
    output logic              alu_start_o,
    input  logic [DATA_W-1:0] alu_hi_i,
    input  logic [DATA_W-1:0] alu_lo_i,
    input  logic              alu_done_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] z_hi_o,
    output logic [DATA_W-1:0] z_lo_o,
    output logic [1:0]        err_o
);

    localparam int CNT_W = $clog2(WDOG + 1);

    state_e              state_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q, z_hi_q, z_lo_q;
    logic [OPC_W-1:0]    alu_op_q;
    logic                alu_start_q, out_valid_q;
    logic                legal_q, multi_q, div0_q;
    logic [1:0]          err_q;
    logic [CNT_W-1:0]    wdog_q;

    logic                dec_legal, dec_multi, dec_shift, dec_unary;
    logic [DATA_W-1:0]   alu_b_d;
    logic                div0_d;

    alu_op_decode u_decode (
        .opcode_i (opcode_i),
        .legal_o  (dec_legal),
        .multi_o  (dec_multi),
        .shift_o  (dec_shift),
        .unary_o  (dec_unary)
    );

    // Operand B normalisation: shifts keep only the amount field, unary ops see zero.
    always_comb begin
        alu_b_d = op_b_i;
        if (dec_shift) begin
            alu_b_d = {{(DATA_W-SHAMT_W){1'b0}}, op_b_i[SHAMT_W-1:0]};
        end else if (dec_unary) begin
            alu_b_d = '0;
        end
    end

    // Divide-by-zero is caught at latch time so the divider is never started.
    assign div0_d = (opcode_i == OP_DIV) && (op_b_i == '0);

    // Sequencing FSM with operand latch, watchdog and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            z_hi_q      <= '0;
            z_lo_q      <= '0;
            err_q       <= ERR_OK;
            legal_q     <= 1'b0;
            multi_q     <= 1'b0;
            div0_q      <= 1'b0;
            wdog_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        alu_a_q     <= op_a_i;
                        alu_b_q     <= alu_b_d;
                        alu_op_q    <= opcode_i;
                        legal_q     <= dec_legal;
                        multi_q     <= dec_multi;
                        div0_q      <= div0_d;
                        // Start pulse coincides with EXEC so the ALU sees stable operands.
                        alu_start_q <= dec_legal && dec_multi && !div0_d;
                        state_q     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_start_q <= 1'b0;
                    if (!legal_q) begin
                        err_q       <= ERR_ILLEGAL;
                        z_hi_q      <= '0;
                        z_lo_q      <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else if (div0_q) begin
                        err_q       <= ERR_DIV0;
                        z_hi_q      <= '0;
                        z_lo_q      <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else if (multi_q) begin
                        wdog_q  <= CNT_W'(WDOG - 1);
                        state_q <= ST_WAIT;
                    end else begin
                        err_q       <= ERR_OK;
                        z_hi_q      <= '0;
                        z_lo_q      <= alu_lo_i;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end
                ST_WAIT: begin
                    if (alu_done_i) begin
                        err_q       <= ERR_OK;
                        z_hi_q      <= alu_hi_i;
                        z_lo_q      <= alu_lo_i;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else if (wdog_q == '0) begin
                        err_q       <= ERR_WDOG;
                        z_hi_q      <= '0;
                        z_lo_q      <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        wdog_q <= wdog_q - CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign alu_start_o = alu_start_q;
    assign out_valid_o = out_valid_q;
    assign z_hi_o      = z_hi_q;
    assign z_lo_o      = z_lo_q;
    assign err_o       = err_q;

endmodule
